// File: rtl/i2s_clock_generator_if.sv
// i2s_clock_generator_if
//   Bundle between the I2S clock generator and the logic it feeds.
//   master : generator side (takes the run request, drives clocks/strobes).
//   slave  : consumer side (drives the run request, observes clocks/strobes).
//   i_ENABLE    run request, level-sensitive
//   o_SCK       bit clock, 50 % duty
//   o_WS        word select, 0 = left slot, 1 = right slot
//   o_SCK_RISE  strobe one i_CLK cycle before o_SCK goes 0->1
//   o_SCK_FALL  strobe one i_CLK cycle before o_SCK goes 1->0
//   o_FrameEnd  the o_SCK_FALL strobe that closes a right slot
//   o_BitIndex  SCK period within the current slot
//   o_Running   generator is active (not idle)
interface i2s_clock_generator_if #(
  parameter int DataWidth = 16
);
  logic                         i_ENABLE;
  logic                         o_SCK;
  logic                         o_WS;
  logic                         o_SCK_RISE;
  logic                         o_SCK_FALL;
  logic                         o_FrameEnd;
  logic [$clog2(DataWidth)-1:0] o_BitIndex;
  logic                         o_Running;

  modport master (
    input  i_ENABLE,
    output o_SCK, o_WS, o_SCK_RISE, o_SCK_FALL, o_FrameEnd, o_BitIndex, o_Running
  );

  modport slave (
    output i_ENABLE,
    input  o_SCK, o_WS, o_SCK_RISE, o_SCK_FALL, o_FrameEnd, o_BitIndex, o_Running
  );
endinterface

// File: rtl/i2s_clock_generator.sv
// i2s_clock_generator
//   Divides i_CLK into a 50 % duty I2S bit clock and derives word select from
//   a per-slot bit counter. Pre-edge strobes let i_CLK-domain logic act one
//   cycle ahead of each SCK edge. Start and stop are frame-aligned.
//   i_CLK     system clock, rising edge
//   i_NRESET  synchronous active-low reset
//   bus       i2s_clock_generator_if.master (enable in; SCK/WS/strobes out)
module i2s_clock_generator #(
  parameter int ClockDivider = 4,
  parameter int DataWidth    = 16
) (
  input  logic                   i_CLK,
  input  logic                   i_NRESET,
  i2s_clock_generator_if.master  bus
);

  localparam int DivW = (ClockDivider > 1) ? $clog2(ClockDivider) : 1;
  localparam int BitW = $clog2(DataWidth);
  localparam logic [DivW-1:0] DivLast = DivW'(ClockDivider - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DataWidth - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t          state, state_n;
  logic [DivW-1:0] div_cnt, div_cnt_n;
  logic [BitW-1:0] bit_cnt, bit_cnt_n;
  logic            sck, sck_n;
  logic            ws, ws_n;

  logic running;
  logic div_wrap;
  logic rise;
  logic fall;
  logic frame_end;

  assign running   = (state != IDLE);
  assign div_wrap  = (div_cnt == DivLast);
  assign rise      = running & ~sck & div_wrap;
  assign fall      = running &  sck & div_wrap;
  assign frame_end = fall & (bit_cnt == BitLast) & ws;

  always_ff @(posedge i_CLK) begin
    if (!i_NRESET) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
      ws      <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_cnt_n;
      bit_cnt <= bit_cnt_n;
      sck     <= sck_n;
      ws      <= ws_n;
    end
  end

  always_comb begin
    state_n   = state;
    div_cnt_n = div_cnt;
    bit_cnt_n = bit_cnt;
    sck_n     = sck;
    ws_n      = ws;
    unique case (state)
      IDLE: begin
        div_cnt_n = '0;
        bit_cnt_n = '0;
        sck_n     = 1'b0;
        ws_n      = 1'b0;
        if (bus.i_ENABLE) state_n = RUN;
      end
      RUN, STOPPING: begin
        // Counting never pauses while stopping; only a frame end with the
        // request still low returns to idle.
        if (div_wrap) begin
          div_cnt_n = '0;
          sck_n     = ~sck;
        end else begin
          div_cnt_n = div_cnt + DivW'(1);
        end
        if (fall) begin
          if (bit_cnt == BitLast) begin
            bit_cnt_n = '0;
            ws_n      = ~ws;
          end else begin
            bit_cnt_n = bit_cnt + BitW'(1);
          end
        end
        state_n = bus.i_ENABLE ? RUN : STOPPING;
        if (state == STOPPING && frame_end && !bus.i_ENABLE) begin
          state_n   = IDLE;
          div_cnt_n = '0;
          bit_cnt_n = '0;
          sck_n     = 1'b0;
          ws_n      = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.o_SCK      = sck;
  assign bus.o_WS       = ws;
  assign bus.o_SCK_RISE = rise;
  assign bus.o_SCK_FALL = fall;
  assign bus.o_FrameEnd = frame_end;
  assign bus.o_BitIndex = bit_cnt;
  assign bus.o_Running  = running;

endmodule

// File: tb/tb_i2s_clock_generator.sv
// tb_i2s_clock_generator
//   Two generator instances (ClockDivider/DataWidth = 4/16 and 1/2), each fed
//   by a directed-then-random enable/reset sequence. A reference model based
//   on "cycles since start of frame" predicts every output cycle; predictions
//   are queued and a separate monitor pops and compares at the falling edge.
module tb_i2s_clock_generator;

  typedef struct packed {
    logic       run;
    logic       sck;
    logic       ws;
    logic       rise;
    logic       fall;
    logic       fe;
    logic [7:0] bidx;
  } obs_t;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int CD = (g == 0) ? 4 : 1;
    localparam int DW = (g == 0) ? 16 : 2;
    localparam int FR = 4 * CD * DW;

    logic        nrst;
    logic        en;
    obs_t        q[$];
    obs_t        act;
    bit          fin;
    bit          armed;
    bit          m_run;
    bit          m_stop;
    int unsigned m_t;

    i2s_clock_generator_if #(.DataWidth(DW)) bus ();
    assign bus.i_ENABLE = en;

    i2s_clock_generator #(
      .ClockDivider(CD),
      .DataWidth   (DW)
    ) dut (
      .i_CLK   (clk),
      .i_NRESET(nrst),
      .bus     (bus.master)
    );

    always_comb begin
      act      = '0;
      act.run  = bus.o_Running;
      act.sck  = bus.o_SCK;
      act.ws   = bus.o_WS;
      act.rise = bus.o_SCK_RISE;
      act.fall = bus.o_SCK_FALL;
      act.fe   = bus.o_FrameEnd;
      act.bidx = 8'(bus.o_BitIndex);
    end

    // Outputs as a function of the position within the frame.
    function automatic obs_t predict();
      obs_t        o;
      int unsigned ph;
      o = '0;
      if (m_run) begin
        ph     = m_t;
        o.run  = 1'b1;
        o.sck  = ((ph / CD) % 2) == 1;
        o.ws   = ph >= FR / 2;
        o.bidx = 8'((ph / (2 * CD)) % DW);
        o.rise = (ph % CD == CD - 1) && !o.sck;
        o.fall = (ph % CD == CD - 1) && o.sck;
        o.fe   = ph == FR - 1;
      end
      return o;
    endfunction

    task automatic step(input logic r, input logic e);
      nrst = r;
      en   = e;
      if (armed) q.push_back(predict());
      @(posedge clk);
      if (!r) begin
        m_run = 0; m_t = 0; m_stop = 0;
      end else if (!m_run) begin
        if (e) begin m_run = 1; m_t = 0; m_stop = 0; end
      end else if (m_stop && !e && m_t == FR - 1) begin
        m_run = 0; m_t = 0; m_stop = 0;
      end else begin
        m_t    = (m_t + 1) % FR;
        m_stop = !e;
      end
      armed = 1;
      #1;
    endtask

    task automatic wait_phase(input int unsigned ph);
      for (int i = 0; i < 2 * FR + 4; i++) begin
        if (m_run && m_t == ph) break;
        step(1'b1, 1'b1);
      end
    endtask

    initial begin
      logic r, e;
      fin = 0; armed = 0; m_run = 0; m_stop = 0; m_t = 0;
      nrst = 1'b0; en = 1'b1;
      repeat (3) step(1'b0, 1'b1);
      repeat (2 * FR + 7) step(1'b1, 1'b1);
      wait_phase(6 * CD);                       // start of bit 3, left slot
      repeat (FR + 10) step(1'b1, 1'b0);
      wait_phase(FR / 2 + CD * DW);             // middle of right slot
      repeat (10) step(1'b1, 1'b0);
      repeat (FR) step(1'b1, 1'b1);
      wait_phase(FR / 2 + 2 * CD * (DW / 2) + CD); // right slot, SCK high
      step(1'b0, 1'b1);
      repeat (FR + 5) step(1'b1, 1'b1);
      e = 1'b1;
      for (int i = 0; i < 8 * FR; i++) begin
        if ($urandom_range(0, FR / 2) == 0) e = ~e;
        r = ($urandom_range(0, 499) != 0);
        step(r, e);
      end
      fin = 1;
    end
  end

  function automatic void check(input string nm, input obs_t e, input obs_t a);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t got run=%0b sck=%0b ws=%0b rise=%0b fall=%0b fe=%0b bit=%0d required run=%0b sck=%0b ws=%0b rise=%0b fall=%0b fe=%0b bit=%0d",
               nm, $time, a.run, a.sck, a.ws, a.rise, a.fall, a.fe, a.bidx,
               e.run, e.sck, e.ws, e.rise, e.fall, e.fe, e.bidx);
    end
  endfunction

  initial begin
    int unsigned n;
    fork
      forever begin
        @(negedge clk);
        if (g_cfg[0].q.size() != 0) check("cfg_div4_w16", g_cfg[0].q.pop_front(), g_cfg[0].act);
        if (g_cfg[1].q.size() != 0) check("cfg_div1_w2", g_cfg[1].q.pop_front(), g_cfg[1].act);
      end
    join_none
    n = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin) && n < 50000) begin
      @(posedge clk);
      n++;
    end
    if (!(g_cfg[0].fin && g_cfg[1].fin)) begin
      errors++;
      $display("FAIL stimulus_timeout got cycles=%0d required completion before 50000", n);
    end
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_clock_generator.md
# i2s_clock_generator

Single-clock I2S bit-clock and word-select generator that drives the `i_SCK` / `i_ChannelSelect` inputs of the I2S master transmitter and receiver. It divides `i_CLK` into a 50 % duty SCK and derives WS from a per-slot bit counter: WS low is the left slot, WS high is the right slot. It also emits pre-edge strobes and frame markers so that `i_CLK`-domain logic (sample fetch, FIFOs) can act exactly one `i_CLK` cycle before each SCK edge. Start and stop are frame-aligned: a stream never ends with a partial stereo frame.

## Interface
Parameters:
- `ClockDivider`, default 4: SCK half-period in `i_CLK` cycles; legal range ≥1.
- `DataWidth`, default 16: SCK periods per channel slot; legal range ≥2.

Ports:
- `i_CLK`  in  1  system clock; all state on rising edge.
- `i_NRESET`  in  1  reset, synchronous, active-low.
- `i_ENABLE`  in  1  run request; level-sensitive.
- `o_SCK`  out  1  bit clock, registered.
- `o_WS`  out  1  word select, registered; 0 = left, 1 = right.
- `o_SCK_RISE`  out  1  high in the `i_CLK` cycle immediately before `o_SCK` goes 0→1.
- `o_SCK_FALL`  out  1  high in the `i_CLK` cycle immediately before `o_SCK` goes 1→0.
- `o_FrameEnd`  out  1  `o_SCK_FALL` that ends a right slot.
- `o_BitIndex`  out  $clog2(DataWidth)  current SCK period within the slot, 0..DataWidth-1.
- `o_Running`  out  1  state ≠ IDLE.

## Operation
Internal registers:
- `div_cnt`: 0..ClockDivider-1.
- `sck`, `ws`.
- `bit_cnt`: 0..DataWidth-1.
- `state`: IDLE, RUN or STOPPING.

Reset (`i_NRESET`=0 at a clock edge):
- `state` = IDLE.
- All counters 0; `sck` = 0, `ws` = 0.
- All outputs 0.
- Reset takes priority over every other event, including mid-frame reset.

State transitions:
- IDLE:
  - Counters are held at 0 and `sck` = `ws` = 0.
  - If `i_ENABLE`=1 → RUN. The first RUN cycle has `div_cnt`=0 and `o_SCK`=0.
- RUN:
  - If `i_ENABLE`=0 → STOPPING. Counting continues uninterrupted.
- STOPPING:
  - If `i_ENABLE`=1 → RUN with no glitch and no counter disturbance.
  - On a frame-end event → IDLE. On the same edge: `sck` ← 0, `ws` ← 0, counters ← 0.
  - If `i_ENABLE` rises on that same frame-end edge, STOPPING→RUN takes priority and the next frame follows seamlessly.

Counting in RUN and STOPPING, each cycle:
- `div_cnt` == ClockDivider-1: `div_cnt` ← 0 and `sck` toggles.
- Otherwise: `div_cnt` increments.

Events (combinational, gated by `o_Running`):
- rise = `~sck` & (`div_cnt` == ClockDivider-1).
- fall = `sck` & (`div_cnt` == ClockDivider-1).
- frame-end = fall & (`bit_cnt` == DataWidth-1) & `ws`.

On a fall event:
- `bit_cnt` == DataWidth-1: `bit_cnt` ← 0 and `ws` toggles.
- Otherwise: `bit_cnt` increments.

Output mapping:
- `o_SCK_RISE` = rise; `o_SCK_FALL` = fall; `o_FrameEnd` = frame-end.
- `o_BitIndex` = `bit_cnt`; `o_Running` = (`state` ≠ IDLE).

WS alignment:
- WS changes on the SCK falling edge that ends the last bit of a slot.
- The downstream transmitter/receiver applies the one-SCK I2S WS delay.

## Timing
- SCK period = 2·ClockDivider `i_CLK` cycles, 50 % duty, for any ClockDivider ≥1.
- ClockDivider=1:
  - `o_SCK` toggles every cycle.
  - Strobes alternate every cycle: RISE, FALL, RISE, …
- Slot = DataWidth SCK periods; frame = 2·DataWidth SCK periods = 4·DataWidth·ClockDivider `i_CLK` cycles.
- Start latency: `o_Running`=1 and the counters begin one `i_CLK` edge after `i_ENABLE` is sampled high.
- First `o_SCK` rise occurs ClockDivider cycles after that.
- Stop latency: from 1 cycle up to 1 frame after `i_ENABLE` falls. `o_Running` drops on the edge following the `o_FrameEnd` cycle.
- Strobes are single-cycle, never overlap, and are 0 whenever `o_Running`=0.
- `o_SCK` and `o_WS` are registered outputs, glitch-free.

## Test plan
- **Reset values.** Hold `i_NRESET`=0 for 3 cycles with `i_ENABLE`=1 → all outputs 0 throughout.
- **Default-parameter cadence** (ClockDivider=4, DataWidth=16). Enable → `o_SCK` period is 8 cycles. `o_WS` reaches 1 after 128 cycles of running. `o_FrameEnd` pulses every 256 cycles. Exactly 16 `o_SCK_RISE` pulses per WS level.
- **Frame-aligned stop.** Deassert `i_ENABLE` at `o_BitIndex`=3 in the left slot → the remainder of the left slot plus the entire right slot completes. `o_FrameEnd` fires; on the next edge `o_Running`=0 and `o_SCK`=`o_WS`=0. Strobes stay 0 afterwards.
- **Re-enable during STOPPING.** Drop `i_ENABLE` for 10 cycles mid-right-slot, then re-raise it → the counter sequence is identical to an uninterrupted run, and `o_Running` never drops.
- **Minimum divider** (ClockDivider=1, DataWidth=2). `o_SCK` toggles every cycle; frame = 8 cycles. `o_BitIndex` sequence is 0,0,1,1 per slot.
- **Mid-frame reset.** Assert `i_NRESET`=0 for 1 cycle mid right slot while `o_SCK`=1 → all outputs 0 next edge. With `i_ENABLE` still high, restart follows the start-latency rule with `o_WS`=0.
